// File: rtl/dct_seq_pkg.sv
// Shared types for the DCT MAC sequencer: FSM states, mode encoding and the
// per-term token that travels down the read-latency pipeline.
package dct_seq_pkg;

    localparam int MAX_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // out_idx is sized for the largest block; narrower blocks zero-extend.
    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [MAX_IDX_W-1:0] out_idx;
    } tok_t;

endpackage

// File: rtl/dct_mac_sequencer_if.sv
// Control and RAM/ROM/MAC strobe bundle between a host and the DCT MAC sequencer.
interface dct_mac_sequencer_if #(
    parameter int LOG2N = 3
);
    localparam int IDX_W = 2 * LOG2N;

    logic                 start;
    logic                 mode;
    logic                 abort;
    logic [IDX_W-1:0]     address;
    logic [4*LOG2N-1:0]   coef_addr;
    logic                 read_enable;
    logic                 active_mac;
    logic                 mac_clear;
    logic                 result_valid;
    logic [IDX_W-1:0]     out_index;
    logic                 busy;
    logic                 ready;

    modport master (
        output start, mode, abort,
        input  address, coef_addr, read_enable, active_mac, mac_clear,
        input  result_valid, out_index, busy, ready
    );

    modport slave (
        input  start, mode, abort,
        output address, coef_addr, read_enable, active_mac, mac_clear,
        output result_valid, out_index, busy, ready
    );

endinterface

// File: rtl/dct_idx_counter.sv
// Cascaded 4-digit counter, digit 0 fastest. wrap[i] is set while digits 0..i are
// all at N-1, i.e. digit i rolls over on the next enabled step.
module dct_idx_counter #(
    parameter int LOG2N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [4*LOG2N-1:0]   cnt,
    output logic [4*LOG2N-1:0]   nxt,
    output logic [3:0]           wrap,
    output logic                 tc
);
    localparam logic [LOG2N-1:0] DIG_MAX = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] DIG_ONE = LOG2N'(1);

    logic [3:0][LOG2N-1:0] dig_q;
    logic [3:0][LOG2N-1:0] dig_d;
    logic [3:0]            carry_s;

    // Rollover status of each digit given all lower digits.
    always_comb begin
        wrap = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                wrap[i] = (dig_q[i] == DIG_MAX);
            end else begin
                wrap[i] = wrap[i-1] && (dig_q[i] == DIG_MAX);
            end
        end
    end

    assign carry_s = {wrap[2:0], 1'b1};

    // Next count: clear wins over enable; each digit steps when all lower ones roll.
    always_comb begin
        dig_d = dig_q;
        if (clr) begin
            dig_d = '0;
        end else if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (carry_s[i]) begin
                    dig_d[i] = dig_q[i] + DIG_ONE;
                end else begin
                    dig_d[i] = dig_q[i];
                end
            end
        end else begin
            dig_d = dig_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_q <= '0;
        end else begin
            dig_q <= dig_d;
        end
    end

    assign cnt = dig_q;
    assign nxt = dig_d;
    assign tc  = wrap[3];

endmodule

// File: rtl/dct_mac_sequencer.sv
// Walks the (outer, inner) index space of an NxN 2-D transform, one operand read
// per cycle, and strobes the MAC RD_LAT cycles later through a token pipeline.
module dct_mac_sequencer
    import dct_seq_pkg::*;
#(
    parameter int LOG2N  = 3,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dct_mac_sequencer_if.slave    bus
);
    localparam int IDX_W = 2 * LOG2N;
    localparam int CW    = 4 * LOG2N;
    localparam logic [MAX_IDX_W-1:0] FINAL_IDX = MAX_IDX_W'((1 << IDX_W) - 1);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  read_en_q, read_en_d;
    logic [IDX_W-1:0]      address_q, address_d;
    logic [CW-1:0]         coef_q, coef_d;
    tok_t                  pipe_q [RD_LAT];
    tok_t                  pipe_d [RD_LAT];
    tok_t                  tok_s;
    logic                  rv_q, rv_d;
    logic [MAX_IDX_W-1:0]  out_idx_q, out_idx_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;

    logic                  cnt_clr_s, cnt_en_s;
    logic [CW-1:0]         cnt_s, nxt_s;
    logic [3:0]            wrap_s;
    logic                  tc_s;
    logic                  final_pt_s;
    logic                  unused_wrap_s;

    dct_idx_counter #(.LOG2N(LOG2N)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_s),
        .en   (cnt_en_s),
        .cnt  (cnt_s),
        .nxt  (nxt_s),
        .wrap (wrap_s),
        .tc   (tc_s)
    );

    assign unused_wrap_s = ^{wrap_s[3:2], wrap_s[0]};
    assign final_pt_s    = rv_q && (out_idx_q == FINAL_IDX);

    // Sequencing FSM; abort overrides everything, including a same-cycle start.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        ready_d   = 1'b0;
        if (bus.abort) begin
            state_d   = IDLE;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d   = ISSUE;
                        mode_d    = bus.mode;
                        cnt_clr_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ISSUE: begin
                    cnt_en_s = 1'b1;
                    if (tc_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
                DRAIN: begin
                    if (final_pt_s) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Address generation and the read-latency token pipeline.
    always_comb begin
        read_en_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
        address_d = nxt_s[IDX_W-1:0];
        if (mode_d == MODE_INV) begin
            coef_d = {nxt_s[IDX_W-1:0], nxt_s[CW-1:IDX_W]};
        end else begin
            coef_d = nxt_s;
        end

        tok_s.valid   = read_en_q;
        tok_s.first   = read_en_q && (cnt_s[IDX_W-1:0] == {IDX_W{1'b0}});
        tok_s.last    = read_en_q && wrap_s[1];
        tok_s.out_idx = MAX_IDX_W'(cnt_s[CW-1:IDX_W]);

        for (int i = 0; i < RD_LAT; i++) begin
            if (bus.abort) begin
                pipe_d[i] = '0;
            end else if (i == 0) begin
                pipe_d[i] = tok_s;
            end else begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        rv_d = !bus.abort && pipe_q[RD_LAT-1].last;
        if (rv_d) begin
            out_idx_d = pipe_q[RD_LAT-1].out_idx;
        end else begin
            out_idx_d = out_idx_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE_FWD;
            read_en_q <= 1'b0;
            address_q <= '0;
            coef_q    <= '0;
            rv_q      <= 1'b0;
            out_idx_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            read_en_q <= read_en_d;
            address_q <= address_d;
            coef_q    <= coef_d;
            rv_q      <= rv_d;
            out_idx_q <= out_idx_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.read_enable  = read_en_q;
    assign bus.address      = address_q;
    assign bus.coef_addr    = coef_q;
    assign bus.active_mac   = pipe_q[RD_LAT-1].valid;
    assign bus.mac_clear    = pipe_q[RD_LAT-1].first;
    assign bus.result_valid = rv_q;
    assign bus.out_index    = out_idx_q[IDX_W-1:0];
    assign bus.busy         = busy_q;
    assign bus.ready        = ready_q;

endmodule
